// File: rtl/seq_div_unit.sv
// rtl/seq_div_unit.sv - multi-cycle restoring divider (signed DIV / unsigned DIVU) for the EX stage
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   signed_div_i 1 = signed DIV, 0 = unsigned DIVU (sampled at start)
//   opdata1_i    dividend (sampled at start)
//   opdata2_i    divisor (sampled at start)
//   start_i      request, held high by EX until ready_o is seen
//   annul_i      abort the current or pending operation
//   result_o     {remainder, quotient}, registered
//   ready_o      result valid, registered
//
// Optional macro DIV_EARLY_TERM_EN: finish at the start edge when the
// dividend magnitude is below the divisor magnitude (quotient 0).
module seq_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam logic [DATA_W-1:0]   ZERO     = '0;
    localparam logic [2*DATA_W-1:0] RES_ZERO = '0;
    localparam logic [CNT_W-1:0]    CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W);

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q;      // partial remainder
    logic [DATA_W-1:0] dvd_q;      // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0] dsr_q;      // divisor magnitude
    logic              sgn_q;
    logic              neg1_q;     // raw dividend sign bit
    logic              neg2_q;     // raw divisor sign bit

    // Operand magnitudes at the start edge
    logic              op1_neg;
    logic              op2_neg;
    logic [DATA_W-1:0] op1_mag;
    logic [DATA_W-1:0] op2_mag;

    // One restoring step
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] dvd_next;

    // Final sign correction
    logic [DATA_W-1:0] quot_fin;
    logic [DATA_W-1:0] rem_fin;

    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_mag = op1_neg ? (ZERO - opdata1_i) : opdata1_i;
        op2_mag = op2_neg ? (ZERO - opdata2_i) : opdata2_i;
    end

    // The partial remainder is always below the divisor, so the shifted value
    // is below twice the divisor and the MSB of the difference is a clean
    // borrow flag: 0 means the subtraction fits.
    always_comb begin
        shifted  = {rem_q, dvd_q[DATA_W-1]};
        diff     = shifted - {1'b0, dsr_q};
        q_bit    = ~diff[DATA_W];
        rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        dvd_next = {dvd_q[DATA_W-2:0], q_bit};
    end

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    // 0x80000000 / -1 wraps naturally back to 0x80000000.
    always_comb begin
        quot_fin = (sgn_q & (neg1_q ^ neg2_q)) ? (ZERO - dvd_q) : dvd_q;
        rem_fin  = (sgn_q & neg1_q) ? (ZERO - rem_q) : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= CNT_ZERO;
            rem_q    <= ZERO;
            dvd_q    <= ZERO;
            dsr_q    <= ZERO;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_o <= RES_ZERO;
            ready_o  <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        sgn_q  <= signed_div_i;
                        neg1_q <= opdata1_i[DATA_W-1];
                        neg2_q <= opdata2_i[DATA_W-1];
                        dsr_q  <= op2_mag;
                        rem_q  <= ZERO;
                        dvd_q  <= op1_mag;
                        cnt_q  <= CNT_ZERO;
                        if (op2_mag == ZERO) begin
                            state_q <= S_BYZERO;
`ifdef DIV_EARLY_TERM_EN
                        end else if (op1_mag < op2_mag) begin
                            // Quotient is zero and the remainder is the
                            // original dividend, sign included.
                            state_q  <= S_END;
                            result_o <= {opdata1_i, ZERO};
                            ready_o  <= 1'b1;
`endif
                        end else begin
                            state_q <= S_ON;
                        end
                    end
                end

                S_BYZERO: begin
                    if (annul_i) begin
                        state_q  <= S_FREE;
                        result_o <= RES_ZERO;
                        ready_o  <= 1'b0;
                    end else begin
                        state_q  <= S_END;
                        result_o <= RES_ZERO;
                        ready_o  <= 1'b1;
                    end
                end

                S_ON: begin
                    if (annul_i) begin
                        state_q  <= S_FREE;
                        result_o <= RES_ZERO;
                        ready_o  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= S_END;
                        result_o <= {rem_fin, quot_fin};
                        ready_o  <= 1'b1;
                    end else begin
                        rem_q <= rem_next;
                        dvd_q <= dvd_next;
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_END: begin
                    // Result is committed; only start_i dropping releases it.
                    if (!start_i) begin
                        state_q  <= S_FREE;
                        result_o <= RES_ZERO;
                        ready_o  <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= S_FREE;
                    result_o <= RES_ZERO;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_unit.sv
// tb/tb_seq_div_unit.sv - directed self-checking bench for seq_div_unit
module tb_seq_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors;
    int checks;

    seq_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_EARLY_TERM_EN
    localparam int EARLY_LAT = 0;
`else
    localparam int EARLY_LAT = 33;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start, take E0, then scramble the operand inputs (they must be
    // ignored) and count cycles after E0 until ready_o, bounded at 40.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        signed_div_i = ~sgn;
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h5A5A_1234;
        lat = 0;
        while (!ready_o && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
    endtask

    task automatic test_unsigned();
        int lat;
        run_div(1'b0, 32'd100, 32'd7, lat);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL u100_7_latency got=%0d exp=33", lat); end
        checks++;
        if (result_o !== {32'h2, 32'hE}) begin errors++; $display("FAIL u100_7_result got=%h exp=%h", result_o, {32'h2, 32'hE}); end
        // Held start with annul in END: result must stay committed
        annul_i = 1'b1;
        tick(); tick();
        annul_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL end_hold_ready got=%b exp=1", ready_o); end
        checks++;
        if (result_o !== {32'h2, 32'hE}) begin errors++; $display("FAIL end_hold_result got=%h exp=%h", result_o, {32'h2, 32'hE}); end
        start_i = 1'b0;
        tick();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL u_drop_ready got=%b exp=0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL u_drop_result got=%h exp=0", result_o); end
    endtask

    task automatic test_signed();
        logic        sv [4];
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [63:0] ev [4];
        int lat;
        sv[0] = 1'b1; av[0] = 32'hFFFF_FFF9; bv[0] = 32'h0000_0002; ev[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        sv[1] = 1'b1; av[1] = 32'h8000_0000; bv[1] = 32'hFFFF_FFFF; ev[1] = {32'h0000_0000, 32'h8000_0000};
        sv[2] = 1'b1; av[2] = 32'h0000_0007; bv[2] = 32'hFFFF_FFFE; ev[2] = {32'h0000_0001, 32'hFFFF_FFFD};
        sv[3] = 1'b0; av[3] = 32'hFFFF_FFF9; bv[3] = 32'h0000_0002; ev[3] = {32'h0000_0001, 32'h7FFF_FFFC};
        for (int i = 0; i < 4; i++) begin
            run_div(sv[i], av[i], bv[i], lat);
            checks++;
            if (lat !== 33) begin errors++; $display("FAIL signed%0d_latency got=%0d exp=33", i, lat); end
            checks++;
            if (result_o !== ev[i]) begin errors++; $display("FAIL signed%0d_result got=%h exp=%h", i, result_o, ev[i]); end
            start_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        for (int s = 0; s < 2; s++) begin
            run_div(s[0], 32'd5, 32'd0, lat);
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL divzero%0d_latency got=%0d exp=1", s, lat); end
            checks++;
            if (result_o !== 64'd0) begin errors++; $display("FAIL divzero%0d_result got=%h exp=0", s, result_o); end
            start_i = 1'b0;
            tick();
            checks++;
            if (ready_o !== 1'b0) begin errors++; $display("FAIL divzero%0d_drop_ready got=%b exp=0", s, ready_o); end
        end
    endtask

    task automatic test_annul();
        int lat;
        logic seen;
        signed_div_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd3;
        start_i = 1'b1;
        tick();                               // E0
        for (int i = 1; i <= 9; i++) tick();  // E1..E9
        annul_i = 1'b1;
        tick();                               // E10
        annul_i = 1'b0;
        start_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL annul_ready got=%b exp=0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL annul_result got=%h exp=0", result_o); end
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        run_div(1'b0, 32'd9, 32'd3, lat);
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL annul_spurious_ready got=%b exp=0", seen); end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL annul_next_latency got=%0d exp=33", lat); end
        checks++;
        if (result_o !== {32'd0, 32'd3}) begin errors++; $display("FAIL annul_next_result got=%h exp=%h", result_o, {32'd0, 32'd3}); end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        signed_div_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd6;
        start_i = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b exp=0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", result_o); end
        tick();
        run_div(1'b0, 32'd20, 32'd6, lat);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL rstmid_next_latency got=%0d exp=33", lat); end
        checks++;
        if (result_o !== {32'd2, 32'd3}) begin errors++; $display("FAIL rstmid_next_result got=%h exp=%h", result_o, {32'd2, 32'd3}); end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_early_term();
        int lat;
        run_div(1'b0, 32'd3, 32'd10, lat);
        checks++;
        if (lat !== EARLY_LAT) begin errors++; $display("FAIL early_u_latency got=%0d exp=%0d", lat, EARLY_LAT); end
        checks++;
        if (result_o !== {32'd3, 32'd0}) begin errors++; $display("FAIL early_u_result got=%h exp=%h", result_o, {32'd3, 32'd0}); end
        start_i = 1'b0;
        tick();
        run_div(1'b1, 32'hFFFF_FFFD, 32'd10, lat);
        checks++;
        if (lat !== EARLY_LAT) begin errors++; $display("FAIL early_s_latency got=%0d exp=%0d", lat, EARLY_LAT); end
        checks++;
        if (result_o !== {32'hFFFF_FFFD, 32'd0}) begin errors++; $display("FAIL early_s_result got=%h exp=%h", result_o, {32'hFFFF_FFFD, 32'd0}); end
        start_i = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_early_term();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
